// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Purpose : shared constants and the state encoding for the serial-bit demux
//           collector (bit_demux_collector and its slot_decoder).
// Contents: DEF_WIDTH / DEF_LOG_WIDTH  default word width and slot index width
//           state_t                    ST_EMPTY = 1'b0, ST_HOLD = 1'b1
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_LOG_WIDTH = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/slot_decoder.sv
// -----------------------------------------------------------------------------
// slot_decoder
// Purpose : turns a slot index plus a valid strobe into a one-hot write enable
//           for the WIDTH-bit shadow register. Indices at or above WIDTH produce
//           no enable at all, so such beats leave every register untouched.
// Ports   : idx       in  LOG_WIDTH  slot index
//           valid     in  1          beat strobe
//           we        out WIDTH      one-hot write enable (all zero if invalid)
//           in_range  out 1          idx addresses an existing slot
// -----------------------------------------------------------------------------
module slot_decoder
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG_WIDTH = DEF_LOG_WIDTH
) (
    input  logic [LOG_WIDTH-1:0] idx,
    input  logic                 valid,
    output logic [WIDTH-1:0]     we,
    output logic                 in_range
);

    always_comb begin
        we       = '0;
        in_range = (int'(idx) < WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            we[i] = valid && in_range && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/bit_demux_collector.sv
// -----------------------------------------------------------------------------
// bit_demux_collector
// Purpose : collects one serial bit per beat into a WIDTH-bit shadow register,
//           either at an explicit slot (sel_i) or at an internal auto-increment
//           pointer. When every slot of the frame has been written, the word is
//           offered on a valid/ready output. Collection keeps running while a
//           word waits; a frame that completes while the output is still
//           occupied (and not being taken that cycle) is dropped and flagged.
// Build   : define DEMUX_PARITY_EN to add word_parity_o (XOR of word_o,
//           registered with it). Without it the port and its logic are absent.
// Ports   : wb_clk_i       in   1          clock, rising edge
//           wb_rst_i       in   1          asynchronous active-high reset
//           bit_i          in   1          serial data bit
//           bit_valid_i    in   1          beat strobe, always accepted
//           sel_i          in   LOG_WIDTH  target slot when auto_inc_i=0
//           auto_inc_i     in   1          use the internal pointer this beat
//           word_o         out  WIDTH      assembled word
//           word_valid_o   out  1          word_o valid
//           word_ready_i   in   1          consumer takes word_o
//           ptr_o          out  LOG_WIDTH  auto-increment pointer
//           overrun_clr_i  in   1          clears overrun_o
//           word_parity_o  out  1          parity of word_o (DEMUX_PARITY_EN)
//           overrun_o      out  1          sticky: a completed frame was dropped
// -----------------------------------------------------------------------------
module bit_demux_collector
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG_WIDTH = DEF_LOG_WIDTH
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 bit_i,
    input  logic                 bit_valid_i,
    input  logic [LOG_WIDTH-1:0] sel_i,
    input  logic                 auto_inc_i,
    output logic [WIDTH-1:0]     word_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic [LOG_WIDTH-1:0] ptr_o,
    input  logic                 overrun_clr_i,
`ifdef DEMUX_PARITY_EN
    output logic                 word_parity_o,
`endif
    output logic                 overrun_o
);

    localparam logic [LOG_WIDTH-1:0] PTR_LAST = LOG_WIDTH'(WIDTH - 1);

    logic [WIDTH-1:0]     shadow;
    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     we;
    logic [WIDTH-1:0]     shadow_next;
    logic [WIDTH-1:0]     mask_next;
    logic [LOG_WIDTH-1:0] ptr;
    logic [LOG_WIDTH-1:0] idx;
    logic                 in_range;
    logic                 hit;
    logic                 complete;
    logic                 load_word;
    logic                 set_overrun;
    state_t               state;
    state_t               state_next;

    assign idx = auto_inc_i ? ptr : sel_i;

    slot_decoder #(
        .WIDTH     (WIDTH),
        .LOG_WIDTH (LOG_WIDTH)
    ) u_slot_decoder (
        .idx      (idx),
        .valid    (bit_valid_i),
        .we       (we),
        .in_range (in_range)
    );

    assign hit         = bit_valid_i & in_range;
    // Shadow/mask as they would be after this beat; the completing bit is
    // therefore already part of shadow_next when the word is captured.
    assign shadow_next = (shadow & ~we) | (we & {WIDTH{bit_i}});
    assign mask_next   = mask | we;
    assign complete    = hit & (&mask_next);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            shadow <= '0;
            mask   <= '0;
            ptr    <= '0;
        end else if (complete) begin
            shadow <= '0;
            mask   <= '0;
            ptr    <= '0;
        end else if (hit) begin
            shadow <= shadow_next;
            mask   <= mask_next;
            if (auto_inc_i) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    // State | meaning
    // ST_EMPTY | no word on the output, word_valid_o = 0
    // ST_HOLD  | word_o offered, word_valid_o = 1, waiting for word_ready_i
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_word   = 1'b0;
        set_overrun = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (complete) begin
                    load_word  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (complete) begin
                    // A word taken in the same cycle frees the slot for the
                    // new one; otherwise the new frame has nowhere to go.
                    if (word_ready_i) begin
                        load_word = 1'b1;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end else if (word_ready_i) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign word_valid_o = (state == ST_HOLD);
    assign ptr_o        = ptr;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            word_o <= '0;
        end else if (load_word) begin
            word_o <= shadow_next;
        end
    end

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overrun_o <= 1'b0;
        end else if (set_overrun) begin
            overrun_o <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            word_parity_o <= 1'b0;
        end else if (load_word) begin
            word_parity_o <= ^shadow_next;
        end
    end
`endif

endmodule

// File: tb/tb_bit_demux_collector.sv
// -----------------------------------------------------------------------------
// tb_bit_demux_collector
// Self-checking bench for bit_demux_collector (WIDTH=32). A slot-array model
// tracks the expected outputs every cycle; directed sequences, a vector table
// and a randomized phase drive the design. Define DEMUX_PARITY_EN to also
// exercise word_parity_o.
// -----------------------------------------------------------------------------
module tb_bit_demux_collector;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        bit_i;
    logic        bit_valid_i;
    logic [4:0]  sel_i;
    logic        auto_inc_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [4:0]  ptr_o;
    logic        overrun_clr_i;
    logic        overrun_o;
`ifdef DEMUX_PARITY_EN
    logic        word_parity_o;
`endif

    bit_demux_collector #(.WIDTH(32), .LOG_WIDTH(5)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .bit_i         (bit_i),
        .bit_valid_i   (bit_valid_i),
        .sel_i         (sel_i),
        .auto_inc_i    (auto_inc_i),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .ptr_o         (ptr_o),
        .overrun_clr_i (overrun_clr_i),
`ifdef DEMUX_PARITY_EN
        .word_parity_o (word_parity_o),
`endif
        .overrun_o     (overrun_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: which slots hold which bit, which slots were written.
    bit          m_slot [32];
    bit          m_wr   [32];
    int          m_ptr;
    bit          m_hold;
    logic [31:0] m_word;
    bit          m_par;
    bit          m_ovr;

    typedef struct {
        bit          b;
        bit          v;
        logic [4:0]  sel;
        bit          rdy;
        logic [31:0] exp_word;
        bit          exp_valid;
        bit          chk_word;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_slot[k] = 1'b0;
            m_wr[k]   = 1'b0;
        end
        m_ptr  = 0;
        m_hold = 1'b0;
        m_word = '0;
        m_par  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit v, input logic [4:0] sel,
                              input bit ai, input bit rdy, input bit clr);
        int          idx;
        bit          done;
        bit          all;
        bit          ovr_set;
        logic [31:0] nw;
        done    = 1'b0;
        ovr_set = 1'b0;
        nw      = '0;
        idx     = ai ? m_ptr : int'(sel);
        if (v && idx < 32) begin
            m_slot[idx] = b;
            m_wr[idx]   = 1'b1;
            if (ai) m_ptr = (m_ptr + 1) % 32;
            all = 1'b1;
            for (int k = 0; k < 32; k++) if (!m_wr[k]) all = 1'b0;
            if (all) begin
                done = 1'b1;
                for (int k = 0; k < 32; k++) begin
                    nw[k]     = m_slot[k];
                    m_slot[k] = 1'b0;
                    m_wr[k]   = 1'b0;
                end
                m_ptr = 0;
            end
        end
        if (!m_hold) begin
            if (done) begin
                m_word = nw;
                m_par  = ^nw;
                m_hold = 1'b1;
            end
        end else if (done) begin
            if (rdy) begin
                m_word = nw;
                m_par  = ^nw;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (rdy) begin
            m_hold = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_model();
        chk("model_word",  word_o,       m_word);
        chk("model_valid", word_valid_o, 32'(m_hold));
        chk("model_ptr",   ptr_o,        32'(m_ptr));
        chk("model_ovr",   overrun_o,    32'(m_ovr));
`ifdef DEMUX_PARITY_EN
        chk("model_par",   word_parity_o, 32'(m_par));
`endif
    endtask

    // One clock: drive at posedge+1, step the model, sample at next posedge+1.
    task automatic cyc(input bit b, input bit v, input logic [4:0] sel,
                       input bit ai, input bit rdy, input bit clr);
        bit_i         = b;
        bit_valid_i   = v;
        sel_i         = sel;
        auto_inc_i    = ai;
        word_ready_i  = rdy;
        overrun_clr_i = clr;
        model_step(b, v, sel, ai, rdy, clr);
        @(posedge wb_clk_i);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        bit_i         = 1'b0;
        bit_valid_i   = 1'b0;
        sel_i         = '0;
        auto_inc_i    = 1'b0;
        word_ready_i  = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    task automatic frame_auto(input logic [31:0] w, input bit rdy_last, input bit clr_last);
        for (int k = 0; k < 32; k++) begin
            cyc(w[k], 1'b1, 5'd0, 1'b1, (k == 31) ? rdy_last : 1'b0, (k == 31) ? clr_last : 1'b0);
        end
    endtask

    initial begin
        vec_t        e;
        logic [31:0] rw;

        // Vector table: manual out-of-order frame, then a frame with slot 5
        // written twice (1 first, 0 later; the later write must win).
        for (int s = 31; s >= 0; s--) begin
            e.b = (s == 0 || s == 31); e.v = 1'b1; e.sel = 5'(s); e.rdy = 1'b0;
            e.exp_word = 32'h80000001; e.exp_valid = (s == 0); e.chk_word = (s == 0);
            tbl.push_back(e);
        end
        e.b = 1'b0; e.v = 1'b0; e.sel = 5'd0; e.rdy = 1'b1;
        e.exp_word = 32'h80000001; e.exp_valid = 1'b0; e.chk_word = 1'b1;
        tbl.push_back(e);
        e.b = 1'b1; e.v = 1'b1; e.sel = 5'd5; e.rdy = 1'b0;
        e.exp_word = 32'h80000001; e.exp_valid = 1'b0; e.chk_word = 1'b0;
        tbl.push_back(e);
        for (int s = 31; s >= 0; s--) begin
            e.b = (s == 0 || s == 31); e.v = 1'b1; e.sel = 5'(s); e.rdy = 1'b0;
            e.exp_word = 32'h80000001; e.exp_valid = (s == 0); e.chk_word = (s == 0);
            tbl.push_back(e);
        end
        e.b = 1'b0; e.v = 1'b0; e.sel = 5'd0; e.rdy = 1'b1;
        e.exp_word = 32'h80000001; e.exp_valid = 1'b0; e.chk_word = 1'b1;
        tbl.push_back(e);

        wb_rst_i = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        chk("reset_word",  word_o,       32'h0);
        chk("reset_valid", word_valid_o, 32'h0);
        chk("reset_ptr",   ptr_o,        32'h0);
        chk("reset_ovr",   overrun_o,    32'h0);
        #9 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // Reset mid-frame while a word is held.
        frame_auto(32'hFFFFFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("midframe_ptr", ptr_o, 32'd10);
        idle_inputs();
        #2 wb_rst_i = 1'b1;
        #1;
        chk("async_rst_word",  word_o,       32'h0);
        chk("async_rst_valid", word_valid_o, 32'h0);
        chk("async_rst_ptr",   ptr_o,        32'h0);
        chk("async_rst_ovr",   overrun_o,    32'h0);
        model_reset();
        #3 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // Auto frame of alternating bits; valid exactly one cycle after beat 31.
        for (int k = 0; k < 32; k++) begin
            cyc(k[0], 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
            if (k == 30) chk("auto_valid_early", word_valid_o, 32'h0);
        end
        chk("auto_valid", word_valid_o, 32'h1);
        chk("auto_word",  word_o,       32'hAAAAAAAA);
        chk("auto_ptr",   ptr_o,        32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("handshake_valid", word_valid_o, 32'h0);
        chk("handshake_word",  word_o,       32'hAAAAAAAA);

        foreach (tbl[i]) begin
            cyc(tbl[i].b, tbl[i].v, tbl[i].sel, 1'b0, tbl[i].rdy, 1'b0);
            chk("tbl_valid", word_valid_o, 32'(tbl[i].exp_valid));
            if (tbl[i].chk_word) chk("tbl_word", word_o, tbl[i].exp_word);
        end

        // Backpressure: second frame completes while first is held.
        frame_auto(32'hFFFFFFFF, 1'b0, 1'b0);
        for (int s = 0; s < 32; s++) cyc(1'($urandom), 1'b1, 5'(s), 1'b0, 1'b0, 1'b0);
        chk("overrun_word", word_o,    32'hFFFFFFFF);
        chk("overrun_set",  overrun_o, 32'h1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("overrun_clr",  overrun_o, 32'h0);
        rw = $urandom;
        frame_auto(rw, 1'b0, 1'b1);
        chk("overrun_set_wins", overrun_o, 32'h1);
        chk("overrun_word2",    word_o,    32'hFFFFFFFF);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("overrun_clr2", overrun_o, 32'h0);

        // Same-cycle handoff.
        frame_auto(32'h12345678, 1'b0, 1'b0);
        frame_auto(32'hCAFEF00D, 1'b1, 1'b0);
        chk("handoff_valid", word_valid_o, 32'h1);
        chk("handoff_word",  word_o,       32'hCAFEF00D);
        chk("handoff_ovr",   overrun_o,    32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

`ifdef DEMUX_PARITY_EN
        frame_auto(32'h00000007, 1'b0, 1'b0);
        chk("parity_7", word_parity_o, 32'h1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        frame_auto(32'h00000003, 1'b0, 1'b0);
        chk("parity_3", word_parity_o, 32'h0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized mix of auto/manual beats, handshakes and clears.
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom), ($urandom_range(3, 0) != 0), 5'($urandom_range(31, 0)),
                1'($urandom), ($urandom_range(15, 0) == 0), ($urandom_range(31, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
